// File: rtl/uart_tx_dev_if.sv
// Bridge-side device bus for the UART transmitter: write strobe, byte address,
// write data and the combinational read-back path.
interface uart_tx_dev_if;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, output addr, output wd, input rd);
  modport slave  (input we, input addr, input wd, output rd);
endinterface

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO, programmable bit divisor,
// status/control registers and a drain interrupt.
module uart_tx_dev #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd217
) (
  input  logic         clk,
  input  logic         sys_rstn,
  uart_tx_dev_if.slave bus,
  output logic         uart_txd,
  output logic         irq
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e             state_q, state_d;
  logic [15:0]        tmr_q, tmr_d;
  logic [15:0]        divl_q, divl_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               txd_q, txd_d;
  logic               irq_q, irq_d;

  logic [15:0]        div_q;
  logic               tx_en_q, irq_en_q, ovf_q;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               wr_data, wr_div, wr_ctrl;
  logic               empty, full, push, pop, launch, tick;
  logic [2:0]         cnt_sat;
  logic               unused_bits;

  assign wr_data = bus.we && (bus.addr[3:2] == 2'd0);
  assign wr_div  = bus.we && (bus.addr[3:2] == 2'd2);
  assign wr_ctrl = bus.we && (bus.addr[3:2] == 2'd3);

  assign empty = (count_q == CNT_W'(0));
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign push  = wr_data && !full;
  assign tick  = (tmr_q == (divl_q - 16'd1));

  assign unused_bits = ^{bus.wd[31:16], bus.addr[1:0]};

  // Frame sequencer; txd_d is the line level for the state being entered.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    divl_d  = divl_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    launch  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (tx_en_q && !empty) launch = 1'b1;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tmr_d   = 16'd0;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      DATA: begin
        if (tick) begin
          tmr_d = 16'd0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            txd_d   = shift_q[1];
          end
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      STOP: begin
        if (tick) begin
          tmr_d = 16'd0;
          if (tx_en_q && !empty) begin
            launch = 1'b1;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
    // Start of a frame: pop the head and freeze the divisor for its duration.
    if (launch) begin
      pop     = 1'b1;
      state_d = START;
      shift_d = mem_q[rptr_q];
      divl_d  = (div_q == 16'd0) ? 16'd1 : div_q;
      tmr_d   = 16'd0;
      txd_d   = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  assign irq_d = irq_en_q && empty && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (!sys_rstn) begin
      state_q  <= IDLE;
      tmr_q    <= 16'd0;
      divl_q   <= 16'd1;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      txd_q    <= 1'b1;
      irq_q    <= 1'b0;
      div_q    <= DEFAULT_DIV;
      tx_en_q  <= 1'b1;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      divl_q  <= divl_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      irq_q   <= irq_d;
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      if (wr_div) div_q <= bus.wd[15:0];
      if (wr_ctrl) begin
        tx_en_q  <= bus.wd[0];
        irq_en_q <= bus.wd[1];
      end
      // A dropped push wins over a same-cycle clear.
      if (wr_data && full)             ovf_q <= 1'b1;
      else if (wr_ctrl && bus.wd[2])   ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.wd[7:0];
  end

  always_comb begin
    cnt_sat = 3'd0;
    if (32'(count_q) > 32'd7) cnt_sat = 3'd7;
    else                      cnt_sat = 3'(count_q);
  end

  always_comb begin
    bus.rd = 32'd0;
    case (bus.addr[3:2])
      2'd1:    bus.rd = {25'd0, ovf_q, cnt_sat, empty, full, (state_q != IDLE)};
      2'd2:    bus.rd = {16'd0, div_q};
      2'd3:    bus.rd = {30'd0, irq_en_q, tx_en_q};
      default: bus.rd = 32'd0;
    endcase
  end

  assign uart_txd = txd_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev: register table plus serial-frame sequences.
module tb_uart_tx_dev;

  logic clk = 1'b0;
  logic sys_rstn;
  logic uart_txd;
  logic irq;
  int   n_checks = 0;
  int   n_errors = 0;

  uart_tx_dev_if bus ();

  uart_tx_dev #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd217)) dut (
    .clk      (clk),
    .sys_rstn (sys_rstn),
    .bus      (bus.slave),
    .uart_txd (uart_txd),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] R_DATA = 2'd0, R_STAT = 2'd1, R_DIV = 2'd2, R_CTRL = 2'd3;

  typedef struct {
    logic        we;
    logic [1:0]  idx;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] d);
    bus.we   = 1'b1;
    bus.addr = {idx, 2'b00};
    bus.wd   = d;
    step();
    bus.we   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] idx, output logic [31:0] v);
    bus.addr = {idx, 2'b00};
    #1;
    v = bus.rd;
  endtask

  // Entered just after the edge of frame cycle 'skip'; leaves just after the frame's last edge.
  task automatic expect_frame(input logic [7:0] b, input int d, input int skip);
    logic [31:0] st;
    logic        exp_bit;
    int          bp;
    for (int n = skip; n < 10 * d; n++) begin
      bp = n / d;
      if (bp == 0)      exp_bit = 1'b0;
      else if (bp == 9) exp_bit = 1'b1;
      else              exp_bit = b[bp-1];
      check($sformatf("txd byte %02h cyc %0d", b, n), {31'd0, uart_txd}, {31'd0, exp_bit});
      rd(R_STAT, st);
      check($sformatf("busy byte %02h cyc %0d", b, n), {31'd0, st[0]}, 32'd1);
      check($sformatf("irq byte %02h cyc %0d", b, n), {31'd0, irq}, 32'd0);
      step();
    end
  endtask

  vec_t        vecs [8];
  logic [31:0] v;
  int          lows;

  initial begin
    bus.we   = 1'b0;
    bus.addr = 4'd0;
    bus.wd   = 32'd0;
    sys_rstn = 1'b0;
    repeat (3) step();
    check("reset txd", {31'd0, uart_txd}, 32'd1);
    check("reset irq", {31'd0, irq}, 32'd0);
    sys_rstn = 1'b1;

    vecs[0] = '{1'b0, R_STAT, 32'd0,          32'h0000_0004};
    vecs[1] = '{1'b0, R_DIV,  32'd0,          32'd217};
    vecs[2] = '{1'b0, R_CTRL, 32'd0,          32'h0000_0001};
    vecs[3] = '{1'b0, R_DATA, 32'd0,          32'd0};
    vecs[4] = '{1'b1, R_DIV,  32'h0000_1234,  32'h0000_1234};
    vecs[5] = '{1'b1, R_DIV,  32'hABCD_0004,  32'h0000_0004};
    vecs[6] = '{1'b1, R_CTRL, 32'h0000_0007,  32'h0000_0003};
    vecs[7] = '{1'b1, R_CTRL, 32'h0000_0000,  32'h0000_0000};
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].we) wr(vecs[i].idx, vecs[i].wd);
      rd(vecs[i].idx, v);
      check($sformatf("reg vec %0d", i), v, vecs[i].exp);
    end
    rd(R_STAT, v);
    check("status after table", v, 32'h0000_0004);

    // DIVISOR=4, single 0x55 frame
    wr(R_CTRL, 32'h1);
    wr(R_DIV, 32'd4);
    wr(R_DATA, 32'h55);
    check("t1 txd before pop", {31'd0, uart_txd}, 32'd1);
    step();
    expect_frame(8'h55, 4, 0);
    rd(R_STAT, v);
    check("t1 status idle", v, 32'h0000_0004);
    check("t1 txd idle", {31'd0, uart_txd}, 32'd1);

    // Overflow with transmitter disabled, then back-to-back drain
    wr(R_CTRL, 32'h0);
    wr(R_DATA, 32'h11);
    wr(R_DATA, 32'h22);
    wr(R_DATA, 32'h33);
    wr(R_DATA, 32'h44);
    wr(R_DATA, 32'h99);
    rd(R_STAT, v);
    check("t2 status full+ovf", v, 32'h0000_0062);
    wr(R_CTRL, 32'h5);
    rd(R_STAT, v);
    check("t2 status ovf cleared", v, 32'h0000_0022);
    step();
    expect_frame(8'h11, 4, 0);
    expect_frame(8'h22, 4, 0);
    expect_frame(8'h33, 4, 0);
    expect_frame(8'h44, 4, 0);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (uart_txd !== 1'b1) lows++;
      step();
    end
    check("t2 no fifth frame", 32'(lows), 32'd0);
    rd(R_STAT, v);
    check("t2 status drained", v, 32'h0000_0004);

    // Interrupt on drain
    wr(R_DIV, 32'd2);
    wr(R_DATA, 32'hA3);
    wr(R_CTRL, 32'h3);
    expect_frame(8'hA3, 2, 0);
    check("t3 irq lag", {31'd0, irq}, 32'd0);
    step();
    check("t3 irq set", {31'd0, irq}, 32'd1);
    wr(R_CTRL, 32'h1);
    check("t3 irq still set", {31'd0, irq}, 32'd1);
    step();
    check("t3 irq cleared", {31'd0, irq}, 32'd0);

    // DIVISOR=0 behaves as one cycle per bit
    wr(R_DIV, 32'd0);
    rd(R_DIV, v);
    check("t4 div reads 0", v, 32'd0);
    wr(R_DATA, 32'hFF);
    check("t4 txd before pop", {31'd0, uart_txd}, 32'd1);
    step();
    expect_frame(8'hFF, 1, 0);
    rd(R_STAT, v);
    check("t4 status idle", v, 32'h0000_0004);

    // Divisor change mid-frame applies to the next frame only
    wr(R_DIV, 32'd3);
    wr(R_DATA, 32'h0F);
    wr(R_DATA, 32'hC4);
    wr(R_DIV, 32'd8);
    expect_frame(8'h0F, 3, 1);
    expect_frame(8'hC4, 8, 0);
    rd(R_STAT, v);
    check("t5 status idle", v, 32'h0000_0004);

    // Reset during data bit 4 with two bytes queued
    wr(R_DIV, 32'd4);
    wr(R_DATA, 32'h4A);
    wr(R_DATA, 32'h3C);
    wr(R_DATA, 32'h77);
    repeat (20) step();
    check("t6 txd bit4", {31'd0, uart_txd}, 32'd0);
    rd(R_STAT, v);
    check("t6 status busy cnt2", v, 32'h0000_0011);
    sys_rstn = 1'b0;
    step();
    check("t6 txd after reset", {31'd0, uart_txd}, 32'd1);
    rd(R_STAT, v);
    check("t6 status after reset", v, 32'h0000_0004);
    rd(R_DIV, v);
    check("t6 div after reset", v, 32'd217);
    rd(R_CTRL, v);
    check("t6 ctrl after reset", v, 32'h0000_0001);
    sys_rstn = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (uart_txd !== 1'b1) lows++;
    end
    check("t6 silent after release", 32'(lows), 32'd0);
    rd(R_STAT, v);
    check("t6 status final", v, 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
